// File: rtl/demux1x3_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x3_reg
//  Description : Registered 1-to-3 demultiplexer with a valid/ready handshake.
//                One input stream is steered by sel_i into one of three
//                independent one-entry output slots (a, b, c). Each slot is
//                drained by its own consumer.
//                Optional feature macro: DEMUX_SEL_ERR_EN
//                  defined   -> sel_i = 2'b11 is illegal. The word is accepted
//                               and dropped, and err_o pulses for one cycle.
//                  undefined -> sel_i = 2'b11 routes to slot c, and err_o
//                               is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x3_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic                  a_valid_o,
    output logic                  b_valid_o,
    output logic                  c_valid_o,
    input  logic                  a_ready_i,
    input  logic                  b_ready_i,
    input  logic                  c_ready_i,
    output logic                  err_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int C_NUM_SLOTS = 3;

    slot_state_t           r_state     [C_NUM_SLOTS];
    slot_state_t           w_state_nxt [C_NUM_SLOTS];
    logic [DATA_WIDTH-1:0] r_data      [C_NUM_SLOTS];

    logic [C_NUM_SLOTS-1:0] w_tgt;       // one-hot destination slot
    logic [C_NUM_SLOTS-1:0] w_slot_rdy;  // consumer ready, per slot
    logic [C_NUM_SLOTS-1:0] w_slot_open; // slot can take a word this cycle
    logic [C_NUM_SLOTS-1:0] w_load;      // slot captures data_i this cycle
    logic                   w_accept;
    logic                   w_ready;
`ifdef DEMUX_SEL_ERR_EN
    logic                   w_illegal;
    logic                   r_err;
`endif

    assign w_slot_rdy = {c_ready_i, b_ready_i, a_ready_i};

    // Decode the select into a one-hot slot target.
`ifdef DEMUX_SEL_ERR_EN
    always_comb begin
        w_tgt     = '0;
        w_illegal = 1'b0;
        case (sel_i)
            2'b00:   w_tgt = 3'b001;
            2'b01:   w_tgt = 3'b010;
            2'b10:   w_tgt = 3'b100;
            default: w_illegal = 1'b1;
        endcase
    end
`else
    always_comb begin
        w_tgt = '0;
        case (sel_i)
            2'b00:   w_tgt = 3'b001;
            2'b01:   w_tgt = 3'b010;
            default: w_tgt = 3'b100;   // 10 and 11 both go to slot c
        endcase
    end
`endif

    // A slot can take a word if it is empty or is being drained in the same cycle.
    always_comb begin
        for (int i = 0; i < C_NUM_SLOTS; i++) begin
            w_slot_open[i] = (r_state[i] == EMPTY) || w_slot_rdy[i];
        end
    end

    // ready_o depends only on the select and the target slot, never on valid_i.
`ifdef DEMUX_SEL_ERR_EN
    assign w_ready = w_illegal || (|(w_tgt & w_slot_open));
`else
    assign w_ready = |(w_tgt & w_slot_open);
`endif

    assign ready_o  = w_ready;
    assign w_accept = valid_i && w_ready;
    assign w_load   = w_tgt & {C_NUM_SLOTS{w_accept}};

    // Per-slot next state: a load always leaves the slot FULL, otherwise a drain empties it.
    always_comb begin
        for (int i = 0; i < C_NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                EMPTY: begin
                    if (w_load[i]) begin
                        w_state_nxt[i] = FULL;
                    end
                end
                FULL: begin
                    if (w_load[i]) begin
                        w_state_nxt[i] = FULL;
                    end else if (w_slot_rdy[i]) begin
                        w_state_nxt[i] = EMPTY;
                    end
                end
                default: w_state_nxt[i] = EMPTY;
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < C_NUM_SLOTS; i++) begin
                r_state[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < C_NUM_SLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Slot data registers load only on accept. They keep stale data while EMPTY.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < C_NUM_SLOTS; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_NUM_SLOTS; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= data_i;
                end
            end
        end
    end

`ifdef DEMUX_SEL_ERR_EN
    // Error flag is high for the cycle after each accepted illegal select.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign a_o       = r_data[0];
    assign b_o       = r_data[1];
    assign c_o       = r_data[2];
    assign a_valid_o = (r_state[0] == FULL);
    assign b_valid_o = (r_state[1] == FULL);
    assign c_valid_o = (r_state[2] == FULL);

endmodule
`default_nettype wire

// File: tb/tb_demux1x3_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x3_reg
//  Description : Self-checking bench for demux1x3_reg. It uses a vector table,
//                a per-slot scoreboard model, and hand-written corner-case
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x3_reg;

`ifdef DEMUX_SEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic [1:0]  sel_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] a_o, b_o, c_o;
    logic        a_valid_o, b_valid_o, c_valid_o;
    logic        a_ready_i = 1'b0, b_ready_i = 1'b0, c_ready_i = 1'b0;
    logic        err_o;

    demux1x3_reg #(.DATA_WIDTH(16), .SEL_WIDTH(2)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .data_i    (data_i),
        .sel_i     (sel_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_o       (a_o),
        .b_o       (b_o),
        .c_o       (c_o),
        .a_valid_o (a_valid_o),
        .b_valid_o (b_valid_o),
        .c_valid_o (c_valid_o),
        .a_ready_i (a_ready_i),
        .b_ready_i (b_ready_i),
        .c_ready_i (c_ready_i),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected slot contents, with one queue per slot.
    bit          m_full [3];
    bit          m_err;
    logic [15:0] q0[$], q1[$], q2[$];

    logic [15:0] dout [3];
    logic        vout [3];
    always_comb begin
        dout[0] = a_o; dout[1] = b_o; dout[2] = c_o;
        vout[0] = a_valid_o; vout[1] = b_valid_o; vout[2] = c_valid_o;
    end

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
        logic        v, ar, br, cr;
        logic        exp_rdy;
        logic [2:0]  exp_v;   // {c, b, a} valids after the edge
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] qfront(input int s);
        case (s)
            0:       return (q0.size() > 0) ? q0[0] : 16'hxxxx;
            1:       return (q1.size() > 0) ? q1[0] : 16'hxxxx;
            default: return (q2.size() > 0) ? q2[0] : 16'hxxxx;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
        m_err = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // One cycle: drive at negedge, check outputs against the model, then advance the model at posedge.
    task automatic step(input logic [15:0] d, input logic [1:0] s, input logic v,
                        input logic ar, input logic br, input logic cr,
                        output logic rdy_seen);
        int         tgt;
        bit         ill;
        bit         exp_rdy;
        bit         acc;
        logic [2:0] rdy;
        @(negedge clk);
        data_i = d; sel_i = s; valid_i = v;
        a_ready_i = ar; b_ready_i = br; c_ready_i = cr;
        #1;
        rdy = {cr, br, ar};
        tgt = int'(s);
        ill = 1'b0;
        if (s == 2'b11) begin
            tgt = 2;
            ill = ERR_EN;
        end
        exp_rdy = ill ? 1'b1 : (!m_full[tgt] || rdy[tgt]);
        rdy_seen = ready_o;
        chk("ready_o", ready_o, exp_rdy);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("slot%0d_valid", i), vout[i], m_full[i]);
            if (m_full[i]) chk($sformatf("slot%0d_data", i), dout[i], qfront(i));
        end
        chk("err_o", err_o, m_err);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (m_full[i] && rdy[i]) begin
                case (i)
                    0:       void'(q0.pop_front());
                    1:       void'(q1.pop_front());
                    default: void'(q2.pop_front());
                endcase
                m_full[i] = 1'b0;
            end
        end
        acc = v && exp_rdy;
        if (acc && !ill) begin
            case (tgt)
                0:       q0.push_back(d);
                1:       q1.push_back(d);
                default: q2.push_back(d);
            endcase
            m_full[tgt] = 1'b1;
        end
        m_err = acc && ill;
    endtask

    initial begin
        logic r;

        vecs[0]  = '{16'h1234, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
        vecs[1]  = '{16'h5555, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
        vecs[2]  = '{16'hBBBB, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011};
        vecs[3]  = '{16'hBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111};
        vecs[4]  = '{16'h7777, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110};
        vecs[5]  = '{16'h2222, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b110};
        vecs[6]  = '{16'h0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[7]  = '{16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000};
        vecs[8]  = '{16'hAAAA, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                     ERR_EN ? 3'b000 : 3'b100};
        vecs[9]  = '{16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, ERR_EN,
                     ERR_EN ? 3'b000 : 3'b100};
        vecs[10] = '{16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000};

        model_reset();

        // Reset state, asserted from time zero with no clock edge yet.
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_valids", {c_valid_o, b_valid_o, a_valid_o}, 3'b000);
        chk("rst_err", err_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int k = 0; k < 11; k++) begin
            step(vecs[k].d, vecs[k].s, vecs[k].v, vecs[k].ar, vecs[k].br, vecs[k].cr, r);
            chk($sformatf("vec%0d_ready", k), r, vecs[k].exp_rdy);
            #1;
            chk($sformatf("vec%0d_valids", k), {c_valid_o, b_valid_o, a_valid_o}, vecs[k].exp_v);
        end

        // Back-to-back drain and refill on slot c.
        for (int k = 0; k < 8; k++) begin
            step(16'(k), 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, r);
            chk("drain_refill_ready", r, 1'b1);
            #1;
            chk("drain_refill_c_o", {15'd0, c_valid_o, c_o}, {15'd0, 1'b1, 16'(k)});
        end
        step(16'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, r);

        // Select 11, as a single accept and then two back-to-back accepts.
        step(16'h00FF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, r);
        #1;
        chk("sel11_err", err_o, ERR_EN);
        chk("sel11_c_valid", c_valid_o, !ERR_EN);
        if (!ERR_EN) chk("sel11_c_o", c_o, 16'h00FF);
        step(16'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, r);
        #1;
        chk("sel11_err_pulse_end", err_o, 1'b0);
        step(16'h0101, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, r);
        step(16'h0202, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, r);
        step(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, r);
        step(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, r);

        // Asynchronous reset mid-stream while slot b is FULL and stalled.
        step(16'h4321, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, r);
        @(negedge clk);
        data_i = 16'h6666; sel_i = 2'b01; valid_i = 1'b1;
        a_ready_i = 1'b0; b_ready_i = 1'b0; c_ready_i = 1'b0;
        #1;
        chk("pre_rst_b_valid", b_valid_o, 1'b1);
        chk("pre_rst_ready", ready_o, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {c_valid_o, b_valid_o, a_valid_o}, 3'b000);
        chk("mid_rst_data", {a_o, b_o, c_o}, 48'h0);
        chk("mid_rst_ready", ready_o, 1'b1);
        chk("mid_rst_err", err_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b0;

        // First accept after reset release.
        step(16'h9999, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, r);
        #1;
        chk("post_rst_a", {15'd0, a_valid_o, a_o}, {15'd0, 1'b1, 16'h9999});
        step(16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, r);
        step(16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
